// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU share arbiter: operator encoding, data word,
// requester tag type and the ALU datapath itself (a pure function, so the top
// level holds exactly one copy of it).
package alu_share_arbiter_pkg;

    typedef logic [31:0] int_t;

    typedef enum logic [2:0] {
        ADD = 3'd0,
        SUB = 3'd1,
        OR  = 3'd2
    } alu_operator_t;

    // Highest legal operator code; anything above it is flagged illegal.
    localparam alu_operator_t ALU_OPERATOR_LAST = OR;

    localparam int NUM_REQUESTERS_DEFAULT = 4;
    localparam int ID_WIDTH_DEFAULT       = $clog2(NUM_REQUESTERS_DEFAULT);

    typedef logic [ID_WIDTH_DEFAULT-1:0] requester_id_t;

    // The shared ALU. Arithmetic wraps modulo 2^32; illegal codes yield 0.
    function automatic int_t alu_execute(input alu_operator_t op, input int_t a, input int_t b);
        case (op)
            ADD:     return a + b;
            SUB:     return a - b;
            OR:      return a | b;
            default: return '0;
        endcase
    endfunction

    function automatic logic alu_is_illegal(input alu_operator_t op);
        return 3'(op) > 3'(ALU_OPERATOR_LAST);
    endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the requesters/consumer and the arbiter.
//   master: requesters + response consumer (drive req_*, resp_ready)
//   slave : the arbiter (drives req_ready, resp_*)
interface alu_share_arbiter_if
    import alu_share_arbiter_pkg::*;
#(
    parameter int NUM_REQUESTERS = 4,
    parameter int ID_WIDTH       = $clog2(NUM_REQUESTERS)
);
    logic          [NUM_REQUESTERS-1:0] req_valid;
    logic          [NUM_REQUESTERS-1:0] req_ready;
    alu_operator_t [NUM_REQUESTERS-1:0] req_operator;
    int_t          [NUM_REQUESTERS-1:0] req_operand1;
    int_t          [NUM_REQUESTERS-1:0] req_operand2;

    logic                resp_valid;
    logic                resp_ready;
    logic [ID_WIDTH-1:0] resp_id;
    int_t                resp_result;
    logic                resp_illegal;

    modport master (
        output req_valid, req_operator, req_operand1, req_operand2, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_result, resp_illegal
    );

    modport slave (
        input  req_valid, req_operator, req_operand1, req_operand2, resp_ready,
        output req_ready, resp_valid, resp_id, resp_result, resp_illegal
    );
endinterface

// File: rtl/alu_share_arbiter_round_robin_arbiter.sv
// Round-robin arbiter. Searches the request vector from rr_pointer upward,
// wrapping at NUM_REQUESTERS, and owns the pointer.
// Ports:
//   clock, reset_n : clock and async active-low reset
//   request        : pending requests
//   enable         : a grant may be issued this cycle
//   grant          : one-hot (or zero) grant, qualified by enable
//   grant_valid    : a grant is issued this cycle
//   grant_index    : index of the winning requester (meaningful with grant_valid)
module round_robin_arbiter #(
    parameter int NUM_REQUESTERS = 4,
    localparam int IW            = $clog2(NUM_REQUESTERS)
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [NUM_REQUESTERS-1:0] request,
    input  logic                      enable,
    output logic [NUM_REQUESTERS-1:0] grant,
    output logic                      grant_valid,
    output logic [IW-1:0]             grant_index
);
    logic [IW-1:0] rr_pointer;
    logic [IW:0]   probe;
    logic          found;

    always_comb begin
        found       = 1'b0;
        grant_index = '0;
        probe       = '0;
        for (int k = 0; k < NUM_REQUESTERS; k++) begin
            // One spare bit so pointer + offset cannot overflow before the wrap.
            probe = {1'b0, rr_pointer} + (IW + 1)'(k);
            if (probe >= (IW + 1)'(NUM_REQUESTERS)) begin
                probe = probe - (IW + 1)'(NUM_REQUESTERS);
            end
            if (!found && request[probe[IW-1:0]]) begin
                found       = 1'b1;
                grant_index = probe[IW-1:0];
            end
        end
    end

    assign grant_valid = found && enable;
    assign grant       = grant_valid ? ({{(NUM_REQUESTERS-1){1'b0}}, 1'b1} << grant_index)
                                     : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_pointer <= '0;
        end else if (grant_valid) begin
            rr_pointer <= (grant_index == IW'(NUM_REQUESTERS - 1)) ? '0 : grant_index + 1'b1;
        end
    end
endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU among NUM_REQUESTERS requesters. One round-robin grant per
// cycle; the winner's operands go through the ALU in the grant cycle and the
// result lands in a single-entry response buffer tagged with the winner's ID.
// Ports:
//   clock, reset_n : clock and async active-low reset
//   bus (slave)    : req_valid/req_ready/req_operator/req_operand1/req_operand2
//                    per requester; resp_valid/resp_ready/resp_id/resp_result/
//                    resp_illegal toward the consumer
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int NUM_REQUESTERS = 4,
    parameter int ID_WIDTH       = $clog2(NUM_REQUESTERS)
) (
    input  logic                clock,
    input  logic                reset_n,
    alu_share_arbiter_if.slave  bus
);
    localparam int IW = $clog2(NUM_REQUESTERS);

    logic          slot_free;
    logic          grant_enable;
    logic          grant_valid;
    logic [IW-1:0] grant_index;
    alu_operator_t sel_operator;
    int_t          sel_operand1;
    int_t          sel_operand2;
    int_t          alu_result;
    logic          alu_illegal;

    // A retire and a new grant may share a cycle, so the slot counts as free
    // while the consumer is accepting. Gating with reset_n keeps req_ready low
    // for the whole reset window.
    assign slot_free    = !bus.resp_valid || bus.resp_ready;
    assign grant_enable = slot_free && reset_n;

    round_robin_arbiter #(
        .NUM_REQUESTERS(NUM_REQUESTERS)
    ) u_arbiter (
        .clock       (clock),
        .reset_n     (reset_n),
        .request     (bus.req_valid),
        .enable      (grant_enable),
        .grant       (bus.req_ready),
        .grant_valid (grant_valid),
        .grant_index (grant_index)
    );

    assign sel_operator = bus.req_operator[grant_index];
    assign sel_operand1 = bus.req_operand1[grant_index];
    assign sel_operand2 = bus.req_operand2[grant_index];

    assign alu_result  = alu_execute(sel_operator, sel_operand1, sel_operand2);
    assign alu_illegal = alu_is_illegal(sel_operator);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.resp_valid   <= 1'b0;
            bus.resp_id      <= '0;
            bus.resp_result  <= '0;
            bus.resp_illegal <= 1'b0;
        end else if (grant_valid) begin
            bus.resp_valid   <= 1'b1;
            bus.resp_id      <= ID_WIDTH'(grant_index);
            bus.resp_result  <= alu_result;
            bus.resp_illegal <= alu_illegal;
        end else if (bus.resp_ready) begin
            bus.resp_valid   <= 1'b0;
        end
    end
endmodule
